decode_stage_pipe: RTL and testbench
====================================

// Module: decode_stage_pipe
// PURPOSE
//  Parametrised ID stage for the 5-stage pipeline: decodes the IF/ID instruction, reads a
//  2R/1W register file and registers the operands and controls into the ID/EX pipeline register.
//  Adds a valid/ready handshake, load-use stall, flush, a write-through bypass and an illegal flag.
//  Sits between fetch and the execute cycle.
// PARAMETERS
//  XLEN    32  data/PC width (>=32); instruction is always 32 bits
//  NREGS   32  architectural registers (16 or 32); index >= NREGS reads 0, writes ignored
//  IMM_SE  1   1 = sign-extend imm16 into ExImm, 0 = zero-extend
// PORTS
//  clk          in   1     clock
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     IF/ID holds a valid Instruction/PC
//  in_ready     out  1     stage accepts the input this cycle
//  Instruction  in   32    instruction word
//  PC           in   XLEN  PC of Instruction
//  wb_en        in   1     write-back enable (from WB stage)
//  wb_rd        in   5     write-back register index
//  DataW        in   XLEN  write-back data
//  ex_ready     in   1     EX accepts the ID/EX register contents
//  flush        in   1     squash the instruction being accepted this cycle (taken branch/jump)
//  out_valid    out  1     ID/EX register valid
//  PC_out, Op1, Op2, ExImm, ExSA  out  XLEN  registered PC, rs1 value, rs2 value, ext imm16, zero-ext sa
//  Rd           out  5     destination index
//  ALUSrc       out  2     00 Op2, 01 ExImm, 10 ExSA
//  ALUOp        out  4     ALU function
//  mem_R, mem_W, WB, RegW  out  1  load, store, WB select memory (1) / ALU (0), register write
//  PC_Src       out  2     00 seq, 01 branch, 10 jump
//  jumpAddress  out  XLEN  {PC[XLEN-1:28], Instruction[25:0], 2'b00}
//  stall        out  1     load-use bubble inserted this cycle
//  illegal      out  1     registered: undefined opcode accepted (decodes as NOP)
// BEHAVIOUR
//  Fields: op[31:26] rd[25:21] rs1[20:16] rs2[15:11] sa[10:6] funct[3:0] imm16[15:0].
//  Decode (unlisted controls 0):
//   0x00 R: ALUOp=funct, ALUSrc=00, RegW=1      0x01 ADDI: ALUOp=0, ALUSrc=01, RegW=1
//   0x02 LW: ALUOp=0, ALUSrc=01, mem_R=1, WB=1, RegW=1
//   0x03 SW: ALUOp=0, ALUSrc=01, mem_W=1, Op2 = store data
//   0x04 BEQ: ALUOp=1, PC_Src=01   0x05 J: PC_Src=10   0x06 SHIFT: ALUOp=funct, ALUSrc=10, RegW=1
//   other: all controls 0, illegal=1.  RegW with rd==0 is forced to 0.
//  Sources: rs1 used by 00,01,02,03,04,06; rs2 used by 00,03,04.
//  Regfile: write on clk when wb_en && wb_rd!=0 && wb_rd<NREGS; reg 0 reads 0. Bypass: read
//   index == wb_rd with a valid write returns DataW in the same cycle. Not cleared by rst.
//  Load-use: out_valid && mem_R && Rd!=0 && Rd matches a used source of the input -> stall=1,
//   in_ready=0, ID/EX loads a bubble (out_valid=0), input held; one-cycle bubble per hazard.
//  Handshake: advance = !out_valid || ex_ready. in_ready = advance && !stall. ID/EX loads on
//   advance: out_valid = in_valid && !stall && !flush. !advance: ID/EX holds, in_ready=0.
//   Bubble or flush loads: out_valid=0, mem_R/mem_W/RegW/PC_Src/illegal=0.
//  flush has priority over stall; flush while !advance has no effect.
//  Latency: 1 cycle from acceptance to out_valid.
//  Reset: all registered outputs 0 (out_valid, controls, data, Rd, illegal); in_ready/stall
//   combinational; rst mid-stall drops the held instruction; regfile contents are not reset.
// TESTING
//  1 rst, then write r3=0x11 via wb; accept ADDI r5,r3,-2 -> next cycle Op1=0x11, ExImm=0xFFFFFFFE, RegW=1.
//  2 LW r4; then ADD r6,r4,r2 -> stall=1, bubble out_valid=0, ADD issues the following cycle.
//  3 wb_en r7=0xABCDEF01 same cycle as R-type reading r7 -> Op1=0xABCDEF01 (bypass).
//  4 J target 0x0000040 at PC=0x10000000 -> jumpAddress=0x10000100, PC_Src=10; flush -> out_valid=0.
//  5 ex_ready=0 for 3 cycles -> outputs held, in_ready=0; write to r0 ignored; op 0x3F -> illegal=1.
//  6 NREGS=16: write r20 ignored, read r20=0; rst mid-stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// ID stage: decodes the IF/ID instruction, reads a 2R/1W register file with write-through
// bypass and loads operands/controls into the ID/EX register under a valid/ready handshake.
module decode_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int IMM_SE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instruction,
    input  logic [XLEN-1:0] PC,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] DataW,
    input  logic            ex_ready,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] Op1,
    output logic [XLEN-1:0] Op2,
    output logic [XLEN-1:0] ExImm,
    output logic [XLEN-1:0] ExSA,
    output logic [4:0]      Rd,
    output logic [1:0]      ALUSrc,
    output logic [3:0]      ALUOp,
    output logic            mem_R,
    output logic            mem_W,
    output logic            WB,
    output logic            RegW,
    output logic [1:0]      PC_Src,
    output logic [XLEN-1:0] jumpAddress,
    output logic            stall,
    output logic            illegal
);

    localparam int IDXW = $clog2(NREGS);

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h01;
    localparam logic [5:0] OP_LW    = 6'h02;
    localparam logic [5:0] OP_SW    = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h05;
    localparam logic [5:0] OP_SHIFT = 6'h06;

    // Instruction fields
    logic [5:0]  f_op;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [4:0]  f_sa;
    logic [3:0]  f_funct;
    logic [15:0] f_imm;

    assign f_op    = Instruction[31:26];
    assign f_rd    = Instruction[25:21];
    assign f_rs1   = Instruction[20:16];
    assign f_rs2   = Instruction[15:11];
    assign f_sa    = Instruction[10:6];
    assign f_funct = Instruction[3:0];
    assign f_imm   = Instruction[15:0];

    // Decoded controls for the instruction at the input
    logic [1:0] dec_alusrc;
    logic [3:0] dec_aluop;
    logic       dec_mem_r;
    logic       dec_mem_w;
    logic       dec_wb;
    logic       dec_regw;
    logic [1:0] dec_pc_src;
    logic       dec_illegal;
    logic       use_rs1;
    logic       use_rs2;

    always_comb begin
        dec_alusrc  = 2'b00;
        dec_aluop   = 4'h0;
        dec_mem_r   = 1'b0;
        dec_mem_w   = 1'b0;
        dec_wb      = 1'b0;
        dec_regw    = 1'b0;
        dec_pc_src  = 2'b00;
        dec_illegal = 1'b0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        case (f_op)
            OP_R: begin
                dec_aluop = f_funct;
                dec_regw  = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OP_ADDI: begin
                dec_alusrc = 2'b01;
                dec_regw   = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_LW: begin
                dec_alusrc = 2'b01;
                dec_mem_r  = 1'b1;
                dec_wb     = 1'b1;
                dec_regw   = 1'b1;
                use_rs1    = 1'b1;
            end
            OP_SW: begin
                dec_alusrc = 2'b01;
                dec_mem_w  = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_BEQ: begin
                dec_aluop  = 4'h1;
                dec_pc_src = 2'b01;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_J: begin
                dec_pc_src = 2'b10;
            end
            OP_SHIFT: begin
                dec_aluop  = f_funct;
                dec_alusrc = 2'b10;
                dec_regw   = 1'b1;
                use_rs1    = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // r0 is hard-wired, so a write to it is never requested downstream
        if (f_rd == 5'd0) begin
            dec_regw = 1'b0;
        end
    end

    // Immediate extension chosen at elaboration time
    logic [XLEN-1:0] imm_ext;

    if (IMM_SE != 0) begin : g_sext
        assign imm_ext = {{(XLEN-16){f_imm[15]}}, f_imm};
    end else begin : g_zext
        assign imm_ext = {{(XLEN-16){1'b0}}, f_imm};
    end

    // Register file: indices outside the implemented range are dropped on write, read as zero
    logic [XLEN-1:0] regs [NREGS];
    logic            wb_ok;

    assign wb_ok = wb_en && (wb_rd != 5'd0) && ({1'b0, wb_rd} < 6'(NREGS));

    always_ff @(posedge clk) begin
        if (wb_ok) begin
            regs[wb_rd[IDXW-1:0]] <= DataW;
        end
    end

    logic [9:0]        rd_idx;
    logic [2*XLEN-1:0] rd_data;

    assign rd_idx = {f_rs2, f_rs1};

    // Port 0 reads rs1, port 1 reads rs2; a same-cycle write-back wins over the stored value
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
        logic [4:0] idx;
        logic       in_range;
        logic       bypass;

        assign idx      = rd_idx[gi*5 +: 5];
        assign in_range = (idx != 5'd0) && ({1'b0, idx} < 6'(NREGS));
        assign bypass   = wb_ok && (wb_rd == idx);
        assign rd_data[gi*XLEN +: XLEN] = !in_range ? '0 :
                                          bypass    ? DataW :
                                                      regs[idx[IDXW-1:0]];
    end

    // Handshake and load-use hazard
    logic advance;
    logic hazard;
    logic flush_eff;
    logic load_valid;

    assign advance   = !out_valid || ex_ready;
    assign hazard    = out_valid && mem_R && (Rd != 5'd0) &&
                       ((use_rs1 && (Rd == f_rs1)) || (use_rs2 && (Rd == f_rs2)));
    assign flush_eff = flush && advance;
    assign stall     = in_valid && hazard && advance && !flush_eff;
    assign in_ready  = advance && !stall;
    assign load_valid = in_valid && !stall && !flush;

    // ID/EX register; bubbles and squashed slots carry no side-effecting controls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            PC_out      <= '0;
            Op1         <= '0;
            Op2         <= '0;
            ExImm       <= '0;
            ExSA        <= '0;
            Rd          <= 5'd0;
            ALUSrc      <= 2'b00;
            ALUOp       <= 4'h0;
            mem_R       <= 1'b0;
            mem_W       <= 1'b0;
            WB          <= 1'b0;
            RegW        <= 1'b0;
            PC_Src      <= 2'b00;
            jumpAddress <= '0;
            illegal     <= 1'b0;
        end else if (advance) begin
            out_valid   <= load_valid;
            PC_out      <= PC;
            Op1         <= rd_data[0 +: XLEN];
            Op2         <= rd_data[XLEN +: XLEN];
            ExImm       <= imm_ext;
            ExSA        <= {{(XLEN-5){1'b0}}, f_sa};
            Rd          <= f_rd;
            ALUSrc      <= load_valid ? dec_alusrc : 2'b00;
            ALUOp       <= load_valid ? dec_aluop  : 4'h0;
            mem_R       <= load_valid && dec_mem_r;
            mem_W       <= load_valid && dec_mem_w;
            WB          <= load_valid && dec_wb;
            RegW        <= load_valid && dec_regw;
            PC_Src      <= load_valid ? dec_pc_src : 2'b00;
            jumpAddress <= {PC[XLEN-1:28], Instruction[25:0], 2'b00};
            illegal     <= load_valid && dec_illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Bench for decode_stage_pipe: scenario tasks drive the stage, a scoreboard queue holds the
// expected ID/EX contents of every accepted instruction and a monitor pops them on transfer.
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, wb_en, ex_ready, flush;
    logic [31:0] Instruction, PC, DataW;
    logic [4:0]  wb_rd;
    logic        out_valid, mem_R, mem_W, WB, RegW, stall, illegal;
    logic [31:0] PC_out, Op1, Op2, ExImm, ExSA, jumpAddress;
    logic [4:0]  Rd;
    logic [1:0]  ALUSrc, PC_Src;
    logic [3:0]  ALUOp;

    decode_stage_pipe #(.XLEN(32), .NREGS(32), .IMM_SE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Instruction(Instruction), .PC(PC), .wb_en(wb_en), .wb_rd(wb_rd), .DataW(DataW),
        .ex_ready(ex_ready), .flush(flush), .out_valid(out_valid), .PC_out(PC_out),
        .Op1(Op1), .Op2(Op2), .ExImm(ExImm), .ExSA(ExSA), .Rd(Rd), .ALUSrc(ALUSrc),
        .ALUOp(ALUOp), .mem_R(mem_R), .mem_W(mem_W), .WB(WB), .RegW(RegW), .PC_Src(PC_Src),
        .jumpAddress(jumpAddress), .stall(stall), .illegal(illegal)
    );

    // Second instance with a 16-entry register file
    logic        s_rst, s_in_valid, s_in_ready, s_wb_en, s_ex_ready, s_flush;
    logic [31:0] s_Instruction, s_PC, s_DataW;
    logic [4:0]  s_wb_rd;
    logic        s_out_valid, s_mem_R, s_mem_W, s_WB, s_RegW, s_stall, s_illegal;
    logic [31:0] s_PC_out, s_Op1, s_Op2, s_ExImm, s_ExSA, s_jumpAddress;
    logic [4:0]  s_Rd;
    logic [1:0]  s_ALUSrc, s_PC_Src;
    logic [3:0]  s_ALUOp;

    decode_stage_pipe #(.XLEN(32), .NREGS(16), .IMM_SE(1)) u_dut16 (
        .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .Instruction(s_Instruction), .PC(s_PC), .wb_en(s_wb_en), .wb_rd(s_wb_rd),
        .DataW(s_DataW), .ex_ready(s_ex_ready), .flush(s_flush), .out_valid(s_out_valid),
        .PC_out(s_PC_out), .Op1(s_Op1), .Op2(s_Op2), .ExImm(s_ExImm), .ExSA(s_ExSA),
        .Rd(s_Rd), .ALUSrc(s_ALUSrc), .ALUOp(s_ALUOp), .mem_R(s_mem_R), .mem_W(s_mem_W),
        .WB(s_WB), .RegW(s_RegW), .PC_Src(s_PC_Src), .jumpAddress(s_jumpAddress),
        .stall(s_stall), .illegal(s_illegal)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] pc, op1, op2, imm, sa, jaddr;
        logic [4:0]  rd;
        logic [1:0]  alusrc, pcsrc;
        logic [3:0]  aluop;
        logic        memr, memw, wb, regw, ill, use1, use2;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_regs [32];

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] sa, input logic [3:0] funct);
        return {op, rd, rs1, rs2, sa, 2'b00, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : model_regs[idx];
    endfunction

    // Reference decode built from the opcode table
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e = '{default: '0};
        e.pc    = pc;
        e.rd    = ins[25:21];
        e.op1   = model_read(ins[20:16]);
        e.op2   = model_read(ins[15:11]);
        e.imm   = {{16{ins[15]}}, ins[15:0]};
        e.sa    = {27'b0, ins[10:6]};
        e.jaddr = {pc[31:28], ins[25:0], 2'b00};
        case (ins[31:26])
            6'h00: begin e.aluop = ins[3:0]; e.regw = 1; e.use1 = 1; e.use2 = 1; end
            6'h01: begin e.alusrc = 2'b01; e.regw = 1; e.use1 = 1; end
            6'h02: begin e.alusrc = 2'b01; e.memr = 1; e.wb = 1; e.regw = 1; e.use1 = 1; end
            6'h03: begin e.alusrc = 2'b01; e.memw = 1; e.use1 = 1; e.use2 = 1; end
            6'h04: begin e.aluop = 4'h1; e.pcsrc = 2'b01; e.use1 = 1; e.use2 = 1; end
            6'h05: begin e.pcsrc = 2'b10; end
            6'h06: begin e.aluop = ins[3:0]; e.alusrc = 2'b10; e.regw = 1; e.use1 = 1; end
            default: e.ill = 1;
        endcase
        if (e.rd == 5'd0) e.regw = 0;
        return e;
    endfunction

    // Scoreboard consumer: compare the ID/EX contents, pop when EX takes them
    exp_t        mon_e;
    logic [17:0] mon_act, mon_exp;
    logic        mon_ok;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: out_valid=1 PC_out=%h, required no output", PC_out);
            end else begin
                mon_e   = sb_q[0];
                mon_act = {Rd, ALUSrc, ALUOp, mem_R, mem_W, WB, RegW, PC_Src, illegal};
                mon_exp = {mon_e.rd, mon_e.alusrc, mon_e.aluop, mon_e.memr, mon_e.memw,
                           mon_e.wb, mon_e.regw, mon_e.pcsrc, mon_e.ill};
                mon_ok  = (PC_out === mon_e.pc) && (ExImm === mon_e.imm) &&
                          (ExSA === mon_e.sa) && (jumpAddress === mon_e.jaddr) &&
                          (mon_act === mon_exp) &&
                          (!mon_e.use1 || (Op1 === mon_e.op1)) &&
                          (!mon_e.use2 || (Op2 === mon_e.op2));
                if (!mon_ok) begin
                    tests_failed++;
                    $display("FAIL sb_idex: got pc=%h op1=%h op2=%h imm=%h sa=%h ja=%h ctl=%h, required pc=%h op1=%h op2=%h imm=%h sa=%h ja=%h ctl=%h",
                             PC_out, Op1, Op2, ExImm, ExSA, jumpAddress, mon_act,
                             mon_e.pc, mon_e.op1, mon_e.op2, mon_e.imm, mon_e.sa, mon_e.jaddr, mon_exp);
                end
                if (ex_ready === 1'b1) void'(sb_q.pop_front());
            end
        end
    end

    // One clock: record write-backs and acceptances before the edge, return just after it
    task automatic step();
        @(negedge clk);
        #1;
        if (wb_en && wb_rd != 5'd0) model_regs[wb_rd] = DataW;
        if (rst) sb_q.delete();
        else if (in_valid && in_ready && !flush) sb_q.push_back(model(Instruction, PC));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid    = v;
        Instruction = ins;
        PC          = pc;
    endtask

    task automatic test_reset();
        rst = 1; ex_ready = 1; flush = 0; wb_en = 0; wb_rd = 0; DataW = 0;
        drive(1'b0, 32'h0, 32'h0);
        step(); step();
        rst = 0;
        tests_run++;
        if (out_valid !== 1'b0 || PC_out !== 32'h0 || Op1 !== 32'h0 || ExImm !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got v=%b pc=%h op1=%h imm=%h, required 0", out_valid, PC_out, Op1, ExImm);
        end
        tests_run++;
        if ({Rd, ALUSrc, ALUOp, mem_R, mem_W, WB, RegW, PC_Src, illegal} !== 18'h0 || jumpAddress !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got rd=%0d alusrc=%b aluop=%h ja=%h, required 0", Rd, ALUSrc, ALUOp, jumpAddress);
        end
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got in_ready=%b stall=%b, required 1/0", in_ready, stall);
        end
    endtask

    task automatic test_addi();
        logic [31:0] vals [4] = '{32'h1000, 32'h22, 32'h11, 32'h4444};
        for (int i = 0; i < 4; i++) begin
            wb_en = 1; wb_rd = 5'(i + 1); DataW = vals[i];
            step();
        end
        wb_en = 0;
        drive(1'b1, enc_i(6'h01, 5'd5, 5'd3, 16'hFFFE), 32'h100);
        step();
        drive(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (out_valid !== 1'b1 || Op1 !== 32'h11 || ExImm !== 32'hFFFFFFFE || RegW !== 1'b1 || ALUSrc !== 2'b01) begin
            tests_failed++;
            $display("FAIL addi: got v=%b op1=%h imm=%h regw=%b alusrc=%b, required 1/00000011/fffffffe/1/01",
                     out_valid, Op1, ExImm, RegW, ALUSrc);
        end
    endtask

    task automatic test_load_use();
        drive(1'b1, enc_i(6'h02, 5'd4, 5'd1, 16'h0008), 32'h104);
        step();
        drive(1'b1, enc_r(6'h00, 5'd6, 5'd4, 5'd2, 5'd0, 4'h0), 32'h108);
        #1;
        tests_run++;
        if (stall !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_stall_rs1: got stall=%b in_ready=%b, required 1/0", stall, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0 || mem_R !== 1'b0 || RegW !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_bubble: got v=%b memR=%b regw=%b, required 0/0/0", out_valid, mem_R, RegW);
        end
        #1;
        tests_run++;
        if (stall !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_release: got stall=%b in_ready=%b, required 0/1", stall, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || Rd !== 5'd6) begin
            tests_failed++;
            $display("FAIL lu_issue: got v=%b rd=%0d, required 1/6", out_valid, Rd);
        end
        // Load to r0 never creates a hazard
        drive(1'b1, enc_i(6'h02, 5'd0, 5'd1, 16'h0000), 32'h10C);
        step();
        drive(1'b1, enc_r(6'h00, 5'd6, 5'd0, 5'd2, 5'd0, 4'h0), 32'h110);
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL lu_r0: got stall=%b, required 0", stall);
        end
        step();
        // Store data (rs2) also counts as a use
        drive(1'b1, enc_i(6'h02, 5'd4, 5'd1, 16'h0004), 32'h114);
        step();
        drive(1'b1, enc_i(6'h03, 5'd0, 5'd1, 16'h2000), 32'h118);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL lu_stall_rs2: got stall=%b, required 1", stall);
        end
        step(); step();
        drive(1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_bypass();
        wb_en = 1; wb_rd = 5'd7; DataW = 32'hABCDEF01;
        drive(1'b1, enc_r(6'h00, 5'd8, 5'd7, 5'd1, 5'd0, 4'h2), 32'h200);
        step();
        wb_en = 0;
        tests_run++;
        if (Op1 !== 32'hABCDEF01) begin
            tests_failed++;
            $display("FAIL bypass: got Op1=%h, required abcdef01", Op1);
        end
        drive(1'b1, enc_r(6'h00, 5'd9, 5'd7, 5'd7, 5'd0, 4'h3), 32'h204);
        step();
        tests_run++;
        if (Op2 !== 32'hABCDEF01) begin
            tests_failed++;
            $display("FAIL stored_after_wb: got Op2=%h, required abcdef01", Op2);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_jump_flush();
        drive(1'b1, {6'h05, 26'h0000040}, 32'h10000000);
        step();
        tests_run++;
        if (jumpAddress !== 32'h10000100 || PC_Src !== 2'b10 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL jump: got ja=%h pcsrc=%b v=%b, required 10000100/10/1", jumpAddress, PC_Src, out_valid);
        end
        drive(1'b1, enc_i(6'h01, 5'd5, 5'd1, 16'h0001), 32'h10000004);
        flush = 1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_ready: got in_ready=%b, required 1", in_ready);
        end
        step();
        flush = 0;
        drive(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (out_valid !== 1'b0 || PC_Src !== 2'b00 || RegW !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_squash: got v=%b pcsrc=%b regw=%b, required 0/00/0", out_valid, PC_Src, RegW);
        end
        // Flush overrides a pending load-use stall
        drive(1'b1, enc_i(6'h02, 5'd4, 5'd1, 16'h0000), 32'h300);
        step();
        drive(1'b1, enc_r(6'h00, 5'd6, 5'd4, 5'd2, 5'd0, 4'h0), 32'h304);
        flush = 1;
        #1;
        tests_run++;
        if (stall !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_over_stall: got stall=%b in_ready=%b, required 0/1", stall, in_ready);
        end
        step();
        flush = 0;
        drive(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_over_stall_out: got v=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, enc_i(6'h01, 5'd10, 5'd1, 16'h0005), 32'h400);
        step();
        ex_ready = 0;
        drive(1'b1, enc_i(6'h01, 5'd11, 5'd2, 16'h0003), 32'h404);
        wb_en = 1; wb_rd = 5'd0; DataW = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_ready[%0d]: got in_ready=%b, required 0", i, in_ready);
            end
            if (i == 1) flush = 1;
            step();
            flush = 0;
            tests_run++;
            if (out_valid !== 1'b1 || PC_out !== 32'h400 || Rd !== 5'd10) begin
                tests_failed++;
                $display("FAIL hold_regs[%0d]: got v=%b pc=%h rd=%0d, required 1/00000400/10", i, out_valid, PC_out, Rd);
            end
        end
        wb_en = 0;
        ex_ready = 1;
        step();
        drive(1'b1, enc_r(6'h00, 5'd12, 5'd0, 5'd0, 5'd0, 4'h0), 32'h408);
        step();
        tests_run++;
        if (Op1 !== 32'h0 || Op2 !== 32'h0 || RegW !== 1'b1) begin
            tests_failed++;
            $display("FAIL r0_read: got op1=%h op2=%h regw=%b, required 0/0/1", Op1, Op2, RegW);
        end
        drive(1'b1, enc_r(6'h00, 5'd0, 5'd1, 5'd2, 5'd0, 4'h0), 32'h40C);
        step();
        tests_run++;
        if (RegW !== 1'b0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd0_regw: got regw=%b v=%b, required 0/1", RegW, out_valid);
        end
        drive(1'b1, {6'h3F, 26'h0}, 32'h410);
        step();
        tests_run++;
        if (illegal !== 1'b1 || RegW !== 1'b0 || ALUOp !== 4'h0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal: got ill=%b regw=%b aluop=%h v=%b, required 1/0/0/1", illegal, RegW, ALUOp, out_valid);
        end
        drive(1'b1, enc_r(6'h06, 5'd13, 5'd1, 5'd0, 5'd7, 4'h9), 32'h414);
        step();
        tests_run++;
        if (illegal !== 1'b0 || ALUSrc !== 2'b10 || ExSA !== 32'h7 || ALUOp !== 4'h9) begin
            tests_failed++;
            $display("FAIL shift: got ill=%b alusrc=%b sa=%h aluop=%h, required 0/10/7/9", illegal, ALUSrc, ExSA, ALUOp);
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_rst_mid_stall();
        drive(1'b1, enc_i(6'h02, 5'd4, 5'd1, 16'h0000), 32'h500);
        step();
        drive(1'b1, enc_r(6'h00, 5'd6, 5'd4, 5'd2, 5'd0, 4'h0), 32'h504);
        #1;
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_stall_pre: got stall=%b, required 1", stall);
        end
        rst = 1;
        step();
        rst = 0;
        drive(1'b0, 32'h0, 32'h0);
        tests_run++;
        if (out_valid !== 1'b0 || PC_out !== 32'h0 || Rd !== 5'd0 || mem_R !== 1'b0 || Op1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_stall: got v=%b pc=%h rd=%0d memR=%b op1=%h, required all 0", out_valid, PC_out, Rd, mem_R, Op1);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_dropped: got v=%b, required 0", out_valid);
        end
    endtask

    task automatic test_nregs16();
        s_rst = 0; s_ex_ready = 1;
        s_wb_en = 1; s_wb_rd = 5'd20; s_DataW = 32'h55;
        @(posedge clk); #1;
        s_wb_rd = 5'd4; s_DataW = 32'h44;
        @(posedge clk); #1;
        s_wb_rd = 5'd5; s_DataW = 32'h66;
        @(posedge clk); #1;
        // write to r20 in the same cycle as a read of r20: neither stored nor forwarded
        s_wb_rd = 5'd20; s_DataW = 32'h77;
        s_in_valid = 1; s_Instruction = enc_r(6'h00, 5'd1, 5'd20, 5'd5, 5'd0, 4'h0);
        @(posedge clk); #1;
        s_wb_en = 0; s_in_valid = 0;
        tests_run++;
        if (s_out_valid !== 1'b1 || s_Op1 !== 32'h0 || s_Op2 !== 32'h66) begin
            tests_failed++;
            $display("FAIL n16_r20: got v=%b op1=%h op2=%h, required 1/0/00000066", s_out_valid, s_Op1, s_Op2);
        end
        s_in_valid = 1; s_Instruction = enc_r(6'h00, 5'd2, 5'd4, 5'd20, 5'd0, 4'h0);
        @(posedge clk); #1;
        s_in_valid = 0;
        tests_run++;
        if (s_Op1 !== 32'h44 || s_Op2 !== 32'h0) begin
            tests_failed++;
            $display("FAIL n16_alias: got op1=%h op2=%h, required 00000044/0", s_Op1, s_Op2);
        end
    endtask

    initial begin
        s_rst = 1; s_in_valid = 0; s_Instruction = 0; s_PC = 0; s_wb_en = 0; s_wb_rd = 0;
        s_DataW = 0; s_ex_ready = 1; s_flush = 0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        test_reset();
        test_addi();
        test_load_use();
        test_bypass();
        test_jump_flush();
        test_back_to_back();
        test_rst_mid_stall();
        test_nregs16();
        step(); step();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: got %0d entries left, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
